// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window on the CPU store path,
// byte FIFO in front of a start/data/stop serialiser, combinational status read port.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  baud_cnt, baud_d;
  logic [2:0]     bit_idx, bit_d;
  logic [7:0]     shifter, shift_d;
  logic           tx_q, tx_d;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic           overflow;

  logic           wr_hit, push_req, clr_req, push_ok, pop;
  logic           full, empty, baud_zero;
  logic           unused_bits;

  // Handshake: push_req is the producer's valid, !full its ready; the FSM's pop is
  // the consumer taking the head and is only raised while !empty.
  assign wr_hit    = write_enable && (write_address[31:3] == BASE_ADDR[31:3]);
  assign push_req  = wr_hit && !write_address[2];
  assign clr_req   = wr_hit &&  write_address[2];
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push_ok   = push_req && !full;
  assign baud_zero = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (clr_req)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shifter  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (baud_zero) state_next = DATA;
      DATA:  if (baud_zero && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (baud_zero) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop always starts a frame: load the byte, drive the start bit, reload the baud timer.
  always_comb begin
    tx_d    = tx_q;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shifter;
    case (state)
      IDLE: begin
        if (pop) begin
          shift_d = fifo_mem[rd_ptr];
          baud_d  = BAUD_MAX;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_zero) begin
          tx_d   = shifter[0];
          bit_d  = 3'd0;
          baud_d = BAUD_MAX;
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_zero) begin
          baud_d = BAUD_MAX;
          if (bit_idx == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            shift_d = {1'b0, shifter[7:1]};
            tx_d    = shifter[1];
            bit_d   = bit_idx + 1'b1;
          end
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_zero) begin
          if (pop) begin
            shift_d = fifo_mem[rd_ptr];
            baud_d  = BAUD_MAX;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = !empty || (state != IDLE);
  assign read_hit = (read_address[31:3] == BASE_ADDR[31:3]);

  always_comb begin
    read_data = '0;
    if (read_hit && read_address[2]) read_data = {28'b0, overflow, busy, empty, full};
  end

  assign unused_bits = ^{write_data[31:8], write_address[1:0], read_address[1:0]};

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU store path, downstream of the core's memory-control outputs. It decodes `write_address`/`write_enable` for its own address window. Accepted bytes are buffered in a small FIFO and serialised as 8N1 frames on `tx`. A status register is exposed on a combinational read port, so firmware can poll FIFO state and use the block as a console/debug output.

Parameters:
BASE_ADDR, 32'h0000_1000, base of the 8-byte register window; must be 8-byte aligned.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
FIFO_DEPTH, 8, byte FIFO entries; power of two, ≥ 2.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
write_address  input  32  store address from CPU memory control
write_data  input  32  store data; only bits [7:0] are used
write_enable  input  1  store strobe, sampled on rising clk
read_address  input  32  load address from CPU memory control
read_data  output  32  combinational register read data
read_hit  output  1  combinational; 1 when read_address falls in this block's window
tx  output  1  serial line, registered, idle high
busy  output  1  1 while FIFO is non-empty or a frame is in progress

Behaviour:
- Register map (address bits [1:0] ignored):
  - BASE+0 TXDATA: write pushes write_data[7:0]; reads return 0.
  - BASE+4 STATUS (read): bit0 = fifo_full, bit1 = fifo_empty, bit2 = busy, bit3 = overflow (sticky), bits[31:4] = 0.
  - BASE+4 STATUS (write): any write clears overflow; the data value is ignored.
  - Hit rule: write_address[31:3] == BASE_ADDR[31:3]. Outside the window, writes are ignored, read_hit = 0 and read_data = 0.
- Reset (rst = 0, asynchronous):
  - tx = 1, state IDLE, FIFO empty (pointers and count = 0), overflow = 0, busy = 0, shifter and baud counter cleared.
  - A reset mid-frame drives tx high immediately and discards all buffered bytes.
- FIFO:
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH) and empty = (count == 0), both evaluated on the pre-edge count.
  - A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
  - Push and pop on the same edge with count in 1..DEPTH-1: count unchanged, both take effect.
  - Push while empty is always accepted. No pop occurs when empty.
  - If a STATUS write (clear) coincides with no overflow event, overflow is cleared. The clear and an overflow event can never coincide, because they are different addresses.
- TX FSM, states IDLE, START, DATA, STOP; baud counter counts CLKS_PER_BIT-1 down to 0.
  - IDLE: if FIFO is non-empty, pop the head into an 8-bit shifter, load the baud counter, set tx = 0 and go to START on the same edge. Consequence: tx falls one clock after the edge that pushed into an empty FIFO.
  - START: hold tx = 0 for CLKS_PER_BIT cycles. On counter expiry, tx = shifter[0], bit index = 0, go to DATA.
  - DATA: each counter expiry shifts right and increments the bit index; LSB is sent first. After bit 7 expires, tx = 1 and go to STOP.
  - STOP: hold tx = 1 for CLKS_PER_BIT cycles. On expiry:
    - if the FIFO is non-empty, pop, set tx = 0 and go directly to START (no idle gap);
    - otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- busy = !empty || state != IDLE. It is combinational from registered state.
- read_data and read_hit have zero latency; they are a pure function of read_address and current state.

Test Plan:
1. Single byte, CLKS_PER_BIT=4: write 0xA5 to BASE+0 at edge E0.
   - tx low from E1 to E5.
   - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles.
   - busy falls at E41; STATUS = 0x2 afterwards.
2. Back-to-back: write 0x55, then 0x0F on the next cycle.
   - 80 contiguous frame cycles with no high gap between the stop bit and the second start bit.
   - Decoded bytes are 0x55 then 0x0F.
3. Overflow, DEPTH=8: 10 consecutive TXDATA writes of 0x01..0x0A.
   - 0x01 is in the shifter, 0x02..0x09 are buffered, 0x0A is dropped.
   - STATUS reads 0xD (full, busy, overflow).
   - Exactly 9 bytes are transmitted. A write to BASE+4 clears bit3.
4. Address decode:
   - write to BASE+8 and to BASE-4 → no transmission, read_hit = 0;
   - read of BASE+5 → read_hit = 1, STATUS returned.
5. Reset mid-frame: assert rst = 0 during the DATA bit 3 of 0xFF with 3 bytes queued.
   - tx = 1 asynchronously; STATUS = 0x2 after release.
   - No further output until the next write.
6. Wrap-around: 20 writes paced at one per frame.
   - Pointers wrap at least twice; all 20 bytes are received in order; overflow stays 0.
